// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter sharing one 4:1 mux between requesters u,v,w,x (0..3).
// Drives the mux select pair {s1,s0} and a one-hot grant. A grant ends on a
// release, on the owner dropping its request, or when the hold limit expires.
// Every grant is followed by at least one idle cycle (grant=0000) so two owners
// never see back-to-back grants.
//
// Request/release handshake: a requester holds req[i] high for as long as it
// wants the mux. It owns the mux while grant[i] is high. It gives the mux up by
// pulsing rel (sampled only while busy) or by dropping req[i]. Changes on other
// req bits during a grant are only looked at once the arbiter is idle again.
// All outputs are registered. dbg_* expose the FSM state, priority pointer and
// hold counter for checkers.
module mux_rr_arbiter #(
    parameter int HOLD_W   = 4,
    parameter int MAX_HOLD = 8
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic [3:0]        req,
    input  logic              rel,
    output logic [3:0]        grant,
    output logic              s0,
    output logic              s1,
    output logic              busy,
    output logic              timeout,
    output logic              dbg_state,
    output logic [1:0]        dbg_ptr,
    output logic [HOLD_W-1:0] dbg_cnt
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // A limit of zero means a grant is never ended by the hold counter.
    localparam bit                HOLD_LIMITED = (MAX_HOLD != 0);
    localparam logic [HOLD_W-1:0] CNT_LAST     = HOLD_LIMITED ? HOLD_W'(MAX_HOLD - 1) : '0;
    localparam logic [HOLD_W-1:0] CNT_MAX      = '1;

    state_t            state;
    logic [1:0]        owner;
    logic [1:0]        ptr;
    logic [HOLD_W-1:0] cnt;

    logic              pick_valid;
    logic [1:0]        pick_idx;
    logic [1:0]        cand;

    logic              end_rel;
    logic              end_drop;
    logic              end_hold;
    logic              end_any;
    logic              end_by_hold_only;

    // Round-robin pick: scan ptr, ptr+1, ptr+2, ptr+3; scanning the offsets in
    // reverse lets the lowest offset with a request win.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = ptr;
        cand       = ptr;
        for (int i = 3; i >= 0; i--) begin
            cand = ptr + 2'(i);
            if (req[cand]) begin
                pick_valid = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    // Grant termination causes, in priority order rel > drop > hold limit.
    // The timeout pulse is reported only when the hold limit is the sole cause.
    always_comb begin
        end_rel          = rel;
        end_drop         = ~req[owner];
        end_hold         = HOLD_LIMITED && (cnt == CNT_LAST);
        end_any          = end_rel | end_drop | end_hold;
        end_by_hold_only = end_hold & ~end_rel & ~end_drop;
    end

    // Arbiter FSM with all outputs registered alongside the state.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state   <= IDLE;
            owner   <= 2'd0;
            ptr     <= 2'd0;
            cnt     <= '0;
            grant   <= 4'b0000;
            busy    <= 1'b0;
            timeout <= 1'b0;
        end else begin
            timeout <= 1'b0;
            case (state)
                IDLE: begin
                    grant <= 4'b0000;
                    if (pick_valid) begin
                        owner <= pick_idx;
                        grant <= 4'b0001 << pick_idx;
                        busy  <= 1'b1;
                        cnt   <= '0;
                        state <= GRANT;
                    end
                end
                GRANT: begin
                    if (end_any) begin
                        // owner is kept so {s1,s0} still points at the old owner
                        state   <= IDLE;
                        grant   <= 4'b0000;
                        busy    <= 1'b0;
                        ptr     <= owner + 2'd1;
                        cnt     <= '0;
                        timeout <= end_by_hold_only;
                    end else if (cnt != CNT_MAX) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    grant <= 4'b0000;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // The mux select follows the registered owner index.
    always_comb begin
        s0        = owner[0];
        s1        = owner[1];
        dbg_state = (state == GRANT);
        dbg_ptr   = ptr;
        dbg_cnt   = cnt;
    end

endmodule
